remote_key_queue: RTL and testbench

Buffers decoded key codes from the IR remote decoder for slower consumers. Detects the rising edge of the decoder's `ready` pulse, discards the invalid code 8'hFF, optionally suppresses auto-repeat, and stores keys in a FIFO. Consumers drain the FIFO through a valid/ready interface. Sits directly downstream of the remote decoder and upstream of the menu/command logic.

---
 rtl/remote_key_queue_pkg.sv | 12 +
 rtl/remote_key_queue_if.sv | 27 ++
 rtl/remote_key_queue_key_fifo.sv | 53 +++++
 rtl/remote_key_queue.sv | 101 ++++++++++
 tb/tb_remote_key_queue.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/remote_key_queue_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : remote_pkg                                                   |
// | Purpose   : Key code width and invalid-code marker shared by the IR       |
// |             remote decoder and the key queue.                            |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package remote_pkg;
  localparam int          KEY_W       = 8;
  localparam logic [7:0]  INVALID_KEY = 8'hFF;
endpackage
`default_nettype wire

// File: rtl/remote_key_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : remote_key_queue_if                                          |
// | Purpose   : Decoder-side key strobe and consumer-side valid/ready bus.    |
// |             master = decoder + consumer side, slave = key queue.         |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
interface remote_key_queue_if;
  import remote_pkg::*;

  logic             key_ready;
  logic [KEY_W-1:0] key_code;
  logic             out_valid;
  logic             out_ready;
  logic [KEY_W-1:0] out_key;

  modport master (
    output key_ready, key_code, out_ready,
    input  out_valid, out_key
  );

  modport slave (
    input  key_ready, key_code, out_ready,
    output out_valid, out_key
  );
endinterface
`default_nettype wire

// File: rtl/remote_key_queue_key_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : key_fifo                                                     |
// | Purpose   : Synchronous first-word-fall-through FIFO. Occupancy counter   |
// |             drives full/empty; pointers wrap naturally (DEPTH = 2^n).     |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  input  wire logic                       push,
  input  wire logic                       pop,
  input  wire logic [WIDTH-1:0]           din,
  output logic      [WIDTH-1:0]           dout,
  output logic      [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; simultaneous push+pop leaves count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/remote_key_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : remote_key_queue                                             |
// | Purpose   : Rising-edge capture of decoded IR keys, invalid-code discard, |
// |             optional auto-repeat suppression, FWFT key buffer with        |
// |             sticky overflow flag.                                        |
// | Options   : REMOTE_KEY_REPEAT_FILTER_EN - builds the repeat filter.      |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module remote_key_queue
  import remote_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int HOLDOFF_CYCLES = 1024
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  remote_key_queue_if.slave               bus,
  output logic      [$clog2(DEPTH+1)-1:0] count,
  output logic                            overflow,
  input  wire logic                       clear_overflow
);
  localparam int            CW     = $clog2(DEPTH+1);
  localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

  logic             r_ready_d;
  logic             r_overflow;
  logic             w_capture;
  logic             w_valid_key;
  logic             w_pass;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [KEY_W-1:0] w_dout;

  // Previous key_ready level for single-capture-per-pulse edge detect.
  always_ff @(posedge clk) begin
    if (reset) r_ready_d <= 1'b0;
    else       r_ready_d <= bus.key_ready;
  end

  assign w_capture   = bus.key_ready && !r_ready_d;
  assign w_valid_key = w_capture && (bus.key_code != INVALID_KEY);

`ifdef REMOTE_KEY_REPEAT_FILTER_EN
  localparam int            TW       = $clog2(HOLDOFF_CYCLES+1);
  localparam logic [TW-1:0] c_HOLD   = TW'(HOLDOFF_CYCLES);

  logic [KEY_W-1:0] r_last_key;
  logic [TW-1:0]    r_timer;

  // Every valid capture, kept or not, re-arms the window; timer saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_key <= INVALID_KEY;
      r_timer    <= c_HOLD;
    end else if (w_valid_key) begin
      r_last_key <= bus.key_code;
      r_timer    <= '0;
    end else if (r_timer < c_HOLD) begin
      r_timer    <= r_timer + TW'(1);
    end
  end

  assign w_pass = !((bus.key_code == r_last_key) && (r_timer < c_HOLD));
`else
  assign w_pass = 1'b1;
`endif

  assign w_full = (count == c_FULL);
  assign w_pop  = bus.out_valid && bus.out_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign w_push = w_valid_key && w_pass && (!w_full || w_pop);
  assign w_drop = w_valid_key && w_pass && w_full && !w_pop;

  key_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (KEY_W)
  ) u_key_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.key_code),
    .dout  (w_dout),
    .count (count)
  );

  // Sticky drop flag; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset)               r_overflow <= 1'b0;
    else if (w_drop)         r_overflow <= 1'b1;
    else if (clear_overflow) r_overflow <= 1'b0;
  end

  assign overflow      = r_overflow;
  assign bus.out_valid = (count != '0);
  assign bus.out_key   = bus.out_valid ? w_dout : INVALID_KEY;
endmodule
`default_nettype wire

// File: tb/tb_remote_key_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_remote_key_queue                                          |
// | Purpose   : Directed vector table plus hand-written sequences for the    |
// |             key queue (fill/overflow, full+pop, repeat filter, reset).   |
// | Options   : REMOTE_KEY_REPEAT_FILTER_EN selects filter expectations.     |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_remote_key_queue;
  localparam int DEPTH = 8;
  localparam int HOLD  = 100;

`ifdef REMOTE_KEY_REPEAT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_overflow;
  logic [3:0] count;
  logic       overflow;
  int         n_chk  = 0;
  int         n_pass = 0;

  remote_key_queue_if bus();

  remote_key_queue #(
    .DEPTH          (DEPTH),
    .HOLDOFF_CYCLES (HOLD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .count          (count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       kr;
    logic [7:0] code;
    logic       ordy;
    logic       clr;
    logic       e_valid;
    logic [7:0] e_key;
    int         e_count;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic pulse(input logic [7:0] c);
    bus.key_ready = 1'b1;
    bus.key_code  = c;
    step();
    bus.key_ready = 1'b0;
    step();
  endtask

  initial begin
    logic [7:0] exp_k;

    //          kr    code   ordy  clr   valid key    cnt ovf
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 0, 1'b0};
    vecs[1]  = '{1'b1, 8'h45, 1'b0, 1'b0, 1'b1, 8'h45, 1, 1'b0};
    vecs[2]  = '{1'b1, 8'h45, 1'b0, 1'b0, 1'b1, 8'h45, 1, 1'b0};
    vecs[3]  = '{1'b1, 8'h45, 1'b0, 1'b0, 1'b1, 8'h45, 1, 1'b0};
    vecs[4]  = '{1'b0, 8'h45, 1'b0, 1'b0, 1'b1, 8'h45, 1, 1'b0};
    vecs[5]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h45, 1, 1'b0};
    vecs[6]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h45, 1, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hFF, 0, 1'b0};
    vecs[8]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 0, 1'b0};
    vecs[9]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF, 0, 1'b0};
    vecs[10] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 1, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hFF, 0, 1'b0};

    reset          = 1'b1;
    clear_overflow = 1'b0;
    bus.key_ready  = 1'b0;
    bus.key_code   = 8'h00;
    bus.out_ready  = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Table: single pulse, held pulse, invalid code, no-bypass when empty.
    for (int i = 0; i < 12; i++) begin
      bus.key_ready  = vecs[i].kr;
      bus.key_code   = vecs[i].code;
      bus.out_ready  = vecs[i].ordy;
      clear_overflow = vecs[i].clr;
      step();
      chk($sformatf("v%0d.valid", i), bus.out_valid, vecs[i].e_valid);
      chk($sformatf("v%0d.key", i),   bus.out_key,   vecs[i].e_key);
      chk($sformatf("v%0d.count", i), count,         vecs[i].e_count);
      chk($sformatf("v%0d.ovf", i),   overflow,      vecs[i].e_ovf);
    end
    bus.key_ready  = 1'b0;
    bus.out_ready  = 1'b0;
    clear_overflow = 1'b0;
    step();

    // Fill beyond capacity, drain in order, then clear the sticky flag.
    for (int k = 1; k <= 9; k++) pulse(8'(k));
    chk("fill.count", count, 8);
    chk("fill.ovf", overflow, 1);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain%0d.valid", k), bus.out_valid, 1);
      chk($sformatf("drain%0d.key", k), bus.out_key, k);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
    end
    chk("drained.count", count, 0);
    chk("drained.key", bus.out_key, 8'hFF);
    chk("drained.ovf_sticky", overflow, 1);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("clear.ovf", overflow, 0);

    // Full queue, capture coincides with pop: accepted, no overflow.
    for (int k = 1; k <= 8; k++) pulse(8'(k));
    chk("full2.count", count, 8);
    bus.key_ready = 1'b1;
    bus.key_code  = 8'h0A;
    bus.out_ready = 1'b1;
    step();
    bus.key_ready = 1'b0;
    bus.out_ready = 1'b0;
    chk("fullpop.count", count, 8);
    chk("fullpop.ovf", overflow, 0);
    for (int k = 0; k < 8; k++) begin
      exp_k = (k < 7) ? 8'(k + 2) : 8'h0A;
      chk($sformatf("fullpop.drain%0d", k), bus.out_key, exp_k);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
    end
    chk("fullpop.empty", count, 0);

    // Auto-repeat: 5 presses 50 cycles apart, then after a long idle gap.
    for (int p = 0; p < 5; p++) begin
      pulse(8'h16);
      repeat (48) step();
    end
    chk("repeat5.count", count, FILT ? 1 : 5);
    chk("repeat5.key", bus.out_key, 8'h16);
    repeat (150) step();
    pulse(8'h16);
    chk("repeat_idle.count", count, FILT ? 2 : 6);
    pulse(8'h18);
    chk("repeat_diff.count", count, FILT ? 3 : 7);
    chk("repeat.ovf", overflow, 0);
    bus.out_ready = 1'b1;
    repeat (10) step();
    bus.out_ready = 1'b0;
    chk("repeat.drain", count, 0);

    // Reset with three queued keys; key_ready held across reset.
    pulse(8'h01);
    pulse(8'h02);
    pulse(8'h03);
    chk("prereset.count", count, 3);
    reset         = 1'b1;
    bus.key_ready = 1'b1;
    bus.key_code  = 8'h55;
    step();
    reset = 1'b0;
    chk("reset.count", count, 0);
    chk("reset.valid", bus.out_valid, 0);
    chk("reset.key", bus.out_key, 8'hFF);
    step();
    bus.key_ready = 1'b0;
    chk("postreset.count", count, 1);
    chk("postreset.key", bus.out_key, 8'h55);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
